// File: rtl/plate_pkg.sv
// Shared definitions for the plate-lane arbiter: code layout, default sizing
// and the issuing-state encoding carried in the top two code bits.
package plate_pkg;

  localparam int CODE_W       = 9;
  localparam int NUM_LANES    = 4;
  localparam int MAX_INFLIGHT = 4;

  localparam int STATE_MSB = 8;
  localparam int STATE_LSB = 7;
  localparam int RTO_MSB   = 6;
  localparam int RTO_LSB   = 4;
  localparam int NUM_MSB   = 3;
  localparam int NUM_LSB   = 0;

  localparam int LANE_W = $clog2(NUM_LANES);
  typedef logic [LANE_W-1:0] lane_id_t;

  typedef enum logic [1:0] {
    ST_KA = 2'd0,
    ST_GJ = 2'd1,
    ST_BR = 2'd2,
    ST_MH = 2'd3
  } plate_state_e;

  function automatic plate_state_e code_state(input logic [CODE_W-1:0] code);
    return plate_state_e'(code[STATE_MSB:STATE_LSB]);
  endfunction

endpackage

// File: rtl/plate_tag_fifo.sv
// In-order FIFO of lane ids for codes that are granted but not yet answered.
// Push and pop may happen in the same cycle; overflow/underflow requests are ignored.
module plate_tag_fifo #(
  parameter int W     = 2,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [W-1:0]             push_data,
  input  logic                     pop,
  output logic [W-1:0]             pop_data,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          push_ok_s, pop_ok_s;

  assign empty    = (count_q == {CW{1'b0}});
  assign full     = (count_q == CW'(DEPTH));
  assign count    = count_q;
  assign pop_data = mem_q[rd_ptr_q];

  // Next pointer and occupancy values.
  always_comb begin
    push_ok_s = push && !full;
    pop_ok_s  = pop && !empty;
    wr_ptr_d  = push_ok_s ? (wr_ptr_q + PW'(1'b1)) : wr_ptr_q;
    rd_ptr_d  = pop_ok_s ? (rd_ptr_q + PW'(1'b1)) : rd_ptr_q;
    case ({push_ok_s, pop_ok_s})
      2'b10:   count_d = count_q + CW'(1'b1);
      2'b01:   count_d = count_q - CW'(1'b1);
      default: count_d = count_q;
    endcase
  end

  // Storage and pointer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= {W{1'b0}};
      wr_ptr_q <= {PW{1'b0}};
      rd_ptr_q <= {PW{1'b0}};
      count_q  <= {CW{1'b0}};
    end else begin
      if (push_ok_s) mem_q[wr_ptr_q] <= push_data;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/plate_lane_arbiter.sv
// Round-robin arbiter sharing one plate recognizer among camera lanes, with
// in-order routing of recognizer results back to the originating lane.
module plate_lane_arbiter #(
  parameter int NUM_LANES    = plate_pkg::NUM_LANES,
  parameter int CODE_W       = plate_pkg::CODE_W,
  parameter int MAX_INFLIGHT = plate_pkg::MAX_INFLIGHT
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_LANES-1:0]          lane_valid,
  input  logic [NUM_LANES*CODE_W-1:0]   lane_code,
  output logic [NUM_LANES-1:0]          lane_ready,
  output logic                          rec_valid,
  output logic [CODE_W-1:0]             rec_code,
  input  logic                          rec_ready,
  input  logic                          res_valid,
  input  logic                          res_hit,
  output logic [NUM_LANES-1:0]          rsp_valid,
  output logic                          rsp_hit,
  output logic [$clog2(MAX_INFLIGHT):0] inflight,
  output logic                          err_spurious
);

  import plate_pkg::*;

  localparam int LW = $clog2(NUM_LANES);
  localparam logic [NUM_LANES-1:0] LANE_ONE  = NUM_LANES'(1'b1);
  localparam logic [LW-1:0]        LAST_LANE = LW'(NUM_LANES - 1);

  logic [LW-1:0]        last_grant_q, last_grant_d;
  logic                 rec_valid_q, rec_valid_d;
  logic [CODE_W-1:0]    rec_code_q, rec_code_d;
  logic [NUM_LANES-1:0] rsp_valid_q, rsp_valid_d;
  logic                 rsp_hit_q, rsp_hit_d;
  logic                 err_q, err_d;

  logic [LW-1:0] idx_s, pick_s, head_s;
  logic          found_s, slot_free_s, grant_s, pop_s;
  logic          fifo_empty_s, fifo_full_s;

  // Search starts just after the last granted lane; the last iteration wraps to it.
  always_comb begin
    found_s = 1'b0;
    pick_s  = last_grant_q;
    idx_s   = last_grant_q;
    for (int i = 1; i <= NUM_LANES; i++) begin
      idx_s = last_grant_q + LW'(i);
      if (!found_s && lane_valid[idx_s]) begin
        found_s = 1'b1;
        pick_s  = idx_s;
      end else begin
        found_s = found_s;
      end
    end
  end

  // Credit is the FIFO's own fullness, so res_valid never reaches lane_ready.
  always_comb begin
    slot_free_s = !rec_valid_q || rec_ready;
    grant_s     = slot_free_s && !fifo_full_s && found_s;
    pop_s       = res_valid && !fifo_empty_s;
    lane_ready  = grant_s ? (LANE_ONE << pick_s) : {NUM_LANES{1'b0}};
  end

  plate_tag_fifo #(
    .W     (LW),
    .DEPTH (MAX_INFLIGHT)
  ) u_tag_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (grant_s),
    .push_data (pick_s),
    .pop       (pop_s),
    .pop_data  (head_s),
    .empty     (fifo_empty_s),
    .full      (fifo_full_s),
    .count     (inflight)
  );

  // Next-state for the recognizer slot, response pulse and error flag.
  always_comb begin
    rec_valid_d  = rec_valid_q;
    rec_code_d   = rec_code_q;
    last_grant_d = last_grant_q;
    if (grant_s) begin
      rec_valid_d  = 1'b1;
      rec_code_d   = lane_code[pick_s*CODE_W +: CODE_W];
      last_grant_d = pick_s;
    end else if (slot_free_s) begin
      rec_valid_d = 1'b0;
    end else begin
      rec_valid_d = rec_valid_q;
    end

    if (pop_s) begin
      rsp_valid_d = LANE_ONE << head_s;
      rsp_hit_d   = res_hit;
    end else begin
      rsp_valid_d = {NUM_LANES{1'b0}};
      rsp_hit_d   = rsp_hit_q;
    end

    err_d = err_q || (res_valid && fifo_empty_s);
  end

  // Output and arbitration-state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_q <= LAST_LANE;
      rec_valid_q  <= 1'b0;
      rec_code_q   <= {CODE_W{1'b0}};
      rsp_valid_q  <= {NUM_LANES{1'b0}};
      rsp_hit_q    <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      last_grant_q <= last_grant_d;
      rec_valid_q  <= rec_valid_d;
      rec_code_q   <= rec_code_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_hit_q    <= rsp_hit_d;
      err_q        <= err_d;
    end
  end

  assign rec_valid    = rec_valid_q;
  assign rec_code     = rec_code_q;
  assign rsp_valid    = rsp_valid_q;
  assign rsp_hit      = rsp_hit_q;
  assign err_spurious = err_q;

endmodule

// File: tb/tb_plate_lane_arbiter.sv
// Directed bench for plate_lane_arbiter: expected recognizer codes and lane
// responses are queued by the stimulus and popped by a negedge monitor.
module tb_plate_lane_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  lane_valid = 4'b0000;
  logic [8:0]  code [4];
  logic [35:0] lane_code;
  logic [3:0]  lane_ready;
  logic        rec_valid;
  logic [8:0]  rec_code;
  logic        rec_ready = 1'b0;
  logic        res_valid = 1'b0;
  logic        res_hit = 1'b0;
  logic [3:0]  rsp_valid;
  logic        rsp_hit;
  logic [2:0]  inflight;
  logic        err_spurious;

  int checks = 0;
  int failures = 0;
  logic [8:0] exp_rec [$];
  int         exp_rsp [$];   // lane*2 + hit
  int         grant_cnt [4];

  assign lane_code = {code[3], code[2], code[1], code[0]};

  plate_lane_arbiter dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .lane_valid   (lane_valid),
    .lane_code    (lane_code),
    .lane_ready   (lane_ready),
    .rec_valid    (rec_valid),
    .rec_code     (rec_code),
    .rec_ready    (rec_ready),
    .res_valid    (res_valid),
    .res_hit      (res_hit),
    .rsp_valid    (rsp_valid),
    .rsp_hit      (rsp_hit),
    .inflight     (inflight),
    .err_spurious (err_spurious)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h at %0t", name, got, want, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_rsp(input int lane, input int hit);
    exp_rsp.push_back(lane * 2 + hit);
  endtask

  task automatic monitor();
    int e;
    logic [8:0] c;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (rec_valid && rec_ready) begin
          if (exp_rec.size() == 0) begin
            chk("rec_unexpected", {23'd0, rec_code}, 32'h1ff);
          end else begin
            c = exp_rec.pop_front();
            chk("rec_code", {23'd0, rec_code}, {23'd0, c});
          end
        end
        if (rsp_valid != 4'b0000) begin
          if (exp_rsp.size() == 0) begin
            chk("rsp_unexpected", {28'd0, rsp_valid}, 32'd0);
          end else begin
            e = exp_rsp.pop_front();
            chk("rsp_valid", {28'd0, rsp_valid}, 32'd1 << (e / 2));
            chk("rsp_hit", {31'd0, rsp_hit}, e % 2);
          end
        end
      end
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    lane_valid = 4'b0000;
    rec_ready = 1'b0;
    res_valid = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
  endtask

  initial begin
    code[0] = 9'h000; code[1] = 9'h000; code[2] = 9'h000; code[3] = 9'h000;
    fork
      monitor();
    join_none

    // Reset values
    do_reset();
    chk("rst_rec_valid", {31'd0, rec_valid}, 32'd0);
    chk("rst_rsp_valid", {28'd0, rsp_valid}, 32'd0);
    chk("rst_inflight", {29'd0, inflight}, 32'd0);
    chk("rst_err", {31'd0, err_spurious}, 32'd0);
    chk("rst_lane_ready", {28'd0, lane_ready}, 32'd0);

    // Single request from lane 0
    code[0] = 9'h012; lane_valid = 4'b0001; rec_ready = 1'b1;
    #1 chk("single_ready", {28'd0, lane_ready}, 32'b0001);
    exp_rec.push_back(9'h012);
    tick();
    lane_valid = 4'b0000;
    tick();
    chk("single_inflight", {29'd0, inflight}, 32'd1);
    res_valid = 1'b1; res_hit = 1'b1; push_rsp(0, 1);
    tick();
    res_valid = 1'b0;
    tick();
    chk("single_rsp_done", {28'd0, rsp_valid}, 32'd0);
    chk("single_inflight0", {29'd0, inflight}, 32'd0);

    // Fairness from a fresh reset, results returned two cycles behind
    do_reset();
    code[0] = 9'h0A0; code[1] = 9'h0A1; code[2] = 9'h0A2; code[3] = 9'h0A3;
    for (int i = 0; i < 4; i++) grant_cnt[i] = 0;
    rec_ready = 1'b1;
    for (int j = 0; j < 16; j++) begin
      lane_valid = 4'b1111;
      if (j >= 2) begin
        res_valid = 1'b1; res_hit = j[0]; push_rsp((j - 2) % 4, j % 2);
      end else begin
        res_valid = 1'b0;
      end
      #1;
      chk("fair_ready", {28'd0, lane_ready}, 32'd1 << (j % 4));
      chk("fair_inflight", {29'd0, inflight}, (j < 2) ? j : 2);
      for (int i = 0; i < 4; i++) grant_cnt[i] += int'(lane_ready[i]);
      exp_rec.push_back(code[j % 4]);
      tick();
    end
    lane_valid = 4'b0000;
    res_valid = 1'b1; res_hit = 1'b0; push_rsp(2, 0);
    tick();
    res_hit = 1'b1; push_rsp(3, 1);
    tick();
    res_valid = 1'b0;
    tick();
    chk("fair_drained", {29'd0, inflight}, 32'd0);
    for (int i = 0; i < 4; i++) chk("fair_share", grant_cnt[i], 32'd4);

    // Backpressure with lane 2 pending
    code[2] = 9'h131; lane_valid = 4'b0100; rec_ready = 1'b1;
    #1 chk("bp_first_ready", {28'd0, lane_ready}, 32'b0100);
    exp_rec.push_back(9'h131);
    tick();
    rec_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("bp_ready_low", {28'd0, lane_ready}, 32'd0);
      chk("bp_rec_valid", {31'd0, rec_valid}, 32'd1);
      chk("bp_rec_code", {23'd0, rec_code}, 32'h131);
      tick();
    end
    rec_ready = 1'b1;
    #1 chk("bp_release_ready", {28'd0, lane_ready}, 32'b0100);
    exp_rec.push_back(9'h131);
    tick();
    lane_valid = 4'b0000;
    tick();
    chk("bp_inflight", {29'd0, inflight}, 32'd2);
    res_valid = 1'b1; res_hit = 1'b0; push_rsp(2, 0);
    tick();
    res_hit = 1'b1; push_rsp(2, 1);
    tick();
    res_valid = 1'b0;
    tick();

    // Credit limit: last grant was lane 2, so order is 3,0,1,2
    code[2] = 9'h0A2; lane_valid = 4'b1111; rec_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("credit_ready", {28'd0, lane_ready}, 32'd1 << ((3 + k) % 4));
      chk("credit_inflight", {29'd0, inflight}, k);
      exp_rec.push_back(code[(3 + k) % 4]);
      tick();
    end
    #1;
    chk("credit_full_ready", {28'd0, lane_ready}, 32'd0);
    chk("credit_full_inflight", {29'd0, inflight}, 32'd4);
    tick();
    chk("credit_hold_ready", {28'd0, lane_ready}, 32'd0);
    res_valid = 1'b1; res_hit = 1'b1; push_rsp(3, 1);
    #1 chk("credit_same_cycle", {28'd0, lane_ready}, 32'd0);
    tick();
    res_valid = 1'b0;
    #1 chk("credit_regrant", {28'd0, lane_ready}, 32'b1000);
    exp_rec.push_back(code[3]);
    tick();
    lane_valid = 4'b0000;
    chk("credit_refull", {29'd0, inflight}, 32'd4);
    for (int d = 0; d < 4; d++) begin
      res_valid = 1'b1; res_hit = d[0]; push_rsp(d, d % 2);
      tick();
    end
    res_valid = 1'b0;
    tick();
    chk("credit_drained", {29'd0, inflight}, 32'd0);

    // Routing order for grants to lanes 3,1,2
    code[3] = 9'h1F3; code[1] = 9'h051; code[2] = 9'h0C2;
    lane_valid = 4'b1000;
    #1 chk("route_g3", {28'd0, lane_ready}, 32'b1000);
    exp_rec.push_back(9'h1F3);
    tick();
    lane_valid = 4'b0010;
    #1 chk("route_g1", {28'd0, lane_ready}, 32'b0010);
    exp_rec.push_back(9'h051);
    tick();
    lane_valid = 4'b0100;
    #1 chk("route_g2", {28'd0, lane_ready}, 32'b0100);
    exp_rec.push_back(9'h0C2);
    tick();
    lane_valid = 4'b0000;
    res_valid = 1'b1; res_hit = 1'b1; push_rsp(3, 1);
    tick();
    res_hit = 1'b0; push_rsp(1, 0);
    tick();
    res_hit = 1'b1; push_rsp(2, 1);
    tick();
    res_valid = 1'b0;
    tick();

    // Spurious result with nothing outstanding
    chk("spur_err_before", {31'd0, err_spurious}, 32'd0);
    res_valid = 1'b1; res_hit = 1'b0;
    tick();
    res_valid = 1'b0;
    chk("spur_err", {31'd0, err_spurious}, 32'd1);
    chk("spur_no_rsp", {28'd0, rsp_valid}, 32'd0);
    chk("spur_hit_hold", {31'd0, rsp_hit}, 32'd1);
    tick();
    chk("spur_err_sticky", {31'd0, err_spurious}, 32'd1);

    // Asynchronous reset in the middle of a stalled transfer
    lane_valid = 4'b0001; rec_ready = 1'b0;
    #1 chk("mid_grant", {28'd0, lane_ready}, 32'b0001);
    tick();
    #1 chk("mid_stall_ready", {28'd0, lane_ready}, 32'd0);
    res_valid = 1'b1; res_hit = 1'b1; push_rsp(0, 1);
    tick();
    res_valid = 1'b0;
    #5;
    lane_valid = 4'b0000;
    rst_n = 1'b0;
    #1;
    chk("ar_rec_valid", {31'd0, rec_valid}, 32'd0);
    chk("ar_rec_code", {23'd0, rec_code}, 32'd0);
    chk("ar_rsp_valid", {28'd0, rsp_valid}, 32'd0);
    chk("ar_rsp_hit", {31'd0, rsp_hit}, 32'd0);
    chk("ar_inflight", {29'd0, inflight}, 32'd0);
    chk("ar_err", {31'd0, err_spurious}, 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    lane_valid = 4'b1111; rec_ready = 1'b1;
    #1 chk("post_rst_lane0", {28'd0, lane_ready}, 32'b0001);
    exp_rec.push_back(code[0]);
    tick();
    lane_valid = 4'b0000;
    tick();
    tick();

    chk("rec_queue_empty", exp_rec.size(), 32'd0);
    chk("rsp_queue_empty", exp_rsp.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
